axp_operand_fetch: RTL

- Issue/operand-fetch stage directly upstream of the integer execute units (opcode 10 adder, 11 logic/cmov, 12 shifter, 08/09 LDA/LDAH, 2x address, 3x branch).
- Holds the 32x64 integer register file and a per-register pending scoreboard.
- Decodes source and destination specifiers, stalls on hazards, and presents cmd, pc and operands a, b, c in one registered output slot with valid/ready handshakes.
- Accepts results from writeback.

---
 rtl/axp_operand_fetch_if.sv | 28 ++
 rtl/axp_operand_fetch.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/axp_operand_fetch_if.sv
// rtl/axp_operand_fetch_if.sv - issue, output slot, writeback and flush signals of the operand-fetch stage
interface axp_operand_fetch_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_cmd;
   logic [63:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_cmd;
   logic [63:0] out_pc;
   logic [63:0] out_a;
   logic [63:0] out_b;
   logic [63:0] out_c;
   logic        wb_en;
   logic [4:0]  wb_reg;
   logic [63:0] wb_data;
   logic        flush;

   modport slave (
      input  in_valid, in_cmd, in_pc, out_ready, wb_en, wb_reg, wb_data, flush,
      output in_ready, out_valid, out_cmd, out_pc, out_a, out_b, out_c
   );

   modport master (
      output in_valid, in_cmd, in_pc, out_ready, wb_en, wb_reg, wb_data, flush,
      input  in_ready, out_valid, out_cmd, out_pc, out_a, out_b, out_c
   );
endinterface

// File: rtl/axp_operand_fetch.sv
// rtl/axp_operand_fetch.sv - integer issue/operand fetch with register file and pending scoreboard
// Build option: define AXP_BYPASS_EN to forward same-cycle writebacks into operands and hazard checks.
module axp_operand_fetch #(
   parameter int NREGS = 32
) (
   input  logic               clock,
   input  logic               reset_n,
   axp_operand_fetch_if.slave bus
);

   localparam logic [4:0]       ZR  = 5'(NREGS - 1);
   localparam logic [NREGS-1:0] ONE = NREGS'(1);
`ifdef AXP_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [63:0]      r_rf [NREGS];
   logic [NREGS-1:0] r_pending;
   logic             r_out_valid;
   logic [31:0]      r_out_cmd;
   logic [63:0]      r_out_pc;
   logic [63:0]      r_out_a;
   logic [63:0]      r_out_b;
   logic [63:0]      r_out_c;
   logic             r_slot_dst_en;
   logic [4:0]       r_slot_dst;

   logic [5:0]       w_op;
   logic [4:0]       w_ra;
   logic [4:0]       w_rb;
   logic [4:0]       w_rc;
   logic [4:0]       w_dst;
   logic             w_is_opr;
   logic             w_use_a;
   logic             w_use_b;
   logic             w_use_c;
   logic             w_dst_en;
   logic             w_wb_hit;
   logic [NREGS-1:0] w_wb_mask;
   logic [NREGS-1:0] w_byp_mask;
   logic [NREGS-1:0] w_pend_eff;
   logic [NREGS-1:0] w_set_mask;
   logic [NREGS-1:0] w_flush_mask;
   logic             w_hazard;
   logic             w_in_ready;
   logic             w_issue;
   logic [63:0]      w_opa;
   logic [63:0]      w_opb;
   logic [63:0]      w_opc;

   assign w_op     = bus.in_cmd[31:26];
   assign w_ra     = bus.in_cmd[25:21];
   assign w_rb     = bus.in_cmd[20:16];
   assign w_rc     = bus.in_cmd[4:0];
   assign w_is_opr = (w_op >= 6'h10) && (w_op <= 6'h13);

   always_comb begin
      w_use_a  = 1'b0;
      w_use_b  = 1'b0;
      w_use_c  = 1'b0;
      w_dst_en = 1'b0;
      w_dst    = w_rc;
      if (w_is_opr) begin
         w_use_a  = 1'b1;
         w_use_b  = ~bus.in_cmd[12];
         w_use_c  = (w_op == 6'h11);
         w_dst_en = 1'b1;
      end else if (((w_op >= 6'h08) && (w_op <= 6'h0F)) || ((w_op >= 6'h20) && (w_op <= 6'h2F))) begin
         w_use_b  = 1'b1;
         w_use_a  = (w_op == 6'h0D) || (w_op == 6'h0E) || (w_op == 6'h0F) ||
                    ((w_op >= 6'h2C) && (w_op <= 6'h2F));
         w_dst_en = ((w_op >= 6'h08) && (w_op <= 6'h0C)) || ((w_op >= 6'h28) && (w_op <= 6'h2B));
         w_dst    = w_ra;
      end else if (w_op >= 6'h30) begin
         w_use_a  = 1'b1;
         w_dst_en = (w_op == 6'h30) || (w_op == 6'h34);
         w_dst    = w_ra;
      end
   end

   // Pending bit of the zero register is never set, so it can never raise a hazard.
   assign w_wb_hit   = bus.wb_en && (bus.wb_reg != ZR);
   assign w_wb_mask  = w_wb_hit ? (ONE << bus.wb_reg) : '0;
   assign w_byp_mask = BYPASS ? w_wb_mask : '0;
   assign w_pend_eff = r_pending & ~w_byp_mask;

   assign w_hazard   = (w_use_a  & w_pend_eff[w_ra]) |
                       (w_use_b  & w_pend_eff[w_rb]) |
                       (w_use_c  & w_pend_eff[w_rc]) |
                       (w_dst_en & w_pend_eff[w_dst]);
   assign w_in_ready = reset_n & ~w_hazard & (~r_out_valid | bus.out_ready) & ~bus.flush;
   assign w_issue    = bus.in_valid & w_in_ready;

   assign w_set_mask   = (w_issue && w_dst_en && (w_dst != ZR)) ? (ONE << w_dst) : '0;
   assign w_flush_mask = (bus.flush && r_out_valid && r_slot_dst_en) ? (ONE << r_slot_dst) : '0;

   assign w_opa = (w_ra == ZR) ? '0 : (w_byp_mask[w_ra] ? bus.wb_data : r_rf[w_ra]);
   assign w_opb = (w_is_opr && bus.in_cmd[12]) ? {56'd0, bus.in_cmd[20:13]} :
                  (w_rb == ZR) ? '0 : (w_byp_mask[w_rb] ? bus.wb_data : r_rf[w_rb]);
   assign w_opc = (w_rc == ZR) ? '0 : (w_byp_mask[w_rc] ? bus.wb_data : r_rf[w_rc]);

   always_ff @(posedge clock) begin
      if (w_wb_hit) begin
         r_rf[bus.wb_reg] <= bus.wb_data;
      end
   end

   // An issue setting a bit wins over a writeback or flush clearing it in the same cycle.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_wb_mask & ~w_flush_mask) | w_set_mask;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_out_valid   <= 1'b0;
         r_out_cmd     <= '0;
         r_out_pc      <= '0;
         r_out_a       <= '0;
         r_out_b       <= '0;
         r_out_c       <= '0;
         r_slot_dst_en <= 1'b0;
         r_slot_dst    <= '0;
      end else if (w_issue) begin
         r_out_valid   <= 1'b1;
         r_out_cmd     <= bus.in_cmd;
         r_out_pc      <= bus.in_pc;
         r_out_a       <= w_opa;
         r_out_b       <= w_opb;
         r_out_c       <= w_opc;
         r_slot_dst_en <= w_dst_en && (w_dst != ZR);
         r_slot_dst    <= w_dst;
      end else if (bus.flush || bus.out_ready) begin
         r_out_valid   <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_cmd   = r_out_cmd;
   assign bus.out_pc    = r_out_pc;
   assign bus.out_a     = r_out_a;
   assign bus.out_b     = r_out_b;
   assign bus.out_c     = r_out_c;

endmodule
